// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU output collector, activation feeder and bench.
// Optional feature: define OUT_RELU_EN to clamp negative requantized elements to zero.
package tpu_pkg;

    localparam int ACC_W      = 24;
    localparam int OUT_W      = 8;
    localparam int NUM_CH     = 3;
    localparam int PIPE_LAT   = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int SHIFT_W    = 5;

    // Token line spans issue edge up to the edge where the last channel is sampled.
    localparam int LINE_LEN = PIPE_LAT + NUM_CH - 1;
    // Wide enough to hold the value FIFO_DEPTH itself.
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] out_t;
    typedef out_t [NUM_CH-1:0]       row_t;
    typedef logic [SHIFT_W-1:0]      shift_t;

    // One slot of the issue token line; shift is captured at issue time.
    typedef struct packed {
        logic   valid;
        shift_t shift;
    } token_t;

    // Requantized element with its clamp flag.
    typedef struct packed {
        logic sat;
        out_t val;
    } req_t;

    // One buffered output row.
    typedef struct packed {
        row_t data;
        logic sat;
    } row_entry_t;

    localparam acc_t OUT_MAX = acc_t'((1 << (OUT_W - 1)) - 1);
    localparam acc_t OUT_MIN = acc_t'(-(1 << (OUT_W - 1)));

    // Arithmetic right shift followed by saturation to the signed OUT_W range.
    function automatic req_t sat_shift(input acc_t acc, input shift_t shift);
        acc_t y;
        req_t r;
        y = acc >>> shift;
`ifdef OUT_RELU_EN
        if (y[ACC_W-1]) begin
            y = '0;
        end
`endif
        r.sat = 1'b0;
        r.val = y[OUT_W-1:0];
        if (y > OUT_MAX) begin
            r.sat = 1'b1;
            r.val = OUT_MAX[OUT_W-1:0];
        end else if (y < OUT_MIN) begin
            r.sat = 1'b1;
            r.val = OUT_MIN[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tpu_oc_fifo.sv
// Synchronous row FIFO for the output collector. Storage is not reset; only pointers and
// occupancy are, so a cleared FIFO reads as empty. Push while full is accepted only when a
// pop happens on the same edge.
module tpu_oc_fifo
    import tpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  row_entry_t               wdata,
    input  logic                     pop,
    output row_entry_t               rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    row_entry_t     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Row storage write port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/tpu_output_collector.sv
// Read-side collector of the systolic MAC array: tracks issued vectors with a token line,
// samples each skewed channel on its own edge, requantizes it, realigns the row, buffers it
// and streams it out. Issue credit guarantees every in-flight row has a FIFO slot.
// Optional feature: define OUT_RELU_EN for ReLU before saturation (see tpu_pkg::sat_shift).
module tpu_output_collector
    import tpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [NUM_CH*ACC_W-1:0]   acc_in,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*OUT_W-1:0]   out_data,
    output logic                      out_sat,
    output logic                      issue_err
);

    localparam int SUM_W = CNT_W + 1;

    token_t            line_q [LINE_LEN];
    req_t              samp [NUM_CH];
    req_t              aligned [NUM_CH];
    row_entry_t        push_row;
    row_entry_t        fifo_head;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  inflight_d;
    logic [SUM_W-1:0]  credit_used;
    logic              issue_fire;
    logic              push;
    logic              pop;
    logic              issue_err_q;

    // Credit counts both rows still in the array and rows already buffered.
    assign credit_used = SUM_W'(inflight_q) + SUM_W'(fifo_count);
    assign issue_ready = (credit_used < SUM_W'(FIFO_DEPTH));
    assign issue_fire  = issue_valid & issue_ready;
    assign push        = line_q[LINE_LEN-1].valid;

    // Token line: one slot per cycle of array latency plus channel skew.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < LINE_LEN; k++) begin
                line_q[k] <= '0;
            end
        end else begin
            line_q[0] <= '{valid: issue_fire, shift: cfg_shift};
            for (int k = 1; k < LINE_LEN; k++) begin
                line_q[k] <= line_q[k-1];
            end
        end
    end

    // Channel i is requantized with the shift of the token that reaches it on this edge.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            samp[i] = sat_shift(acc_t'(acc_in[i*ACC_W +: ACC_W]),
                                line_q[PIPE_LAT-1+i].shift);
        end
    end

    // Deskew: channel g waits NUM_CH-1-g cycles so the whole row lines up with the last one.
    for (genvar g = 0; g < NUM_CH - 1; g++) begin : g_dsk
        localparam int STAGES = NUM_CH - 1 - g;
        req_t dly_q [STAGES];

        // Capture on the channel's token, then age one stage per cycle.
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                for (int s = 0; s < STAGES; s++) begin
                    dly_q[s] <= '0;
                end
            end else begin
                if (line_q[PIPE_LAT-1+g].valid) begin
                    dly_q[0] <= samp[g];
                end
                for (int s = 1; s < STAGES; s++) begin
                    dly_q[s] <= dly_q[s-1];
                end
            end
        end

        assign aligned[g] = dly_q[STAGES-1];
    end

    // The last channel is sampled on the push edge itself.
    assign aligned[NUM_CH-1] = samp[NUM_CH-1];

    // Assemble the row written into the FIFO; sat is the OR of element clamps.
    always_comb begin
        push_row.sat = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            push_row.data[i] = aligned[i].val;
            push_row.sat     = push_row.sat | aligned[i].sat;
        end
    end

    // In-flight count: up on accepted issue, down on push, unchanged when both happen.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue_fire, push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Credit counter and sticky issue-protocol error.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            inflight_q  <= '0;
            issue_err_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (issue_valid && !issue_ready) begin
                issue_err_q <= 1'b1;
            end
        end
    end

    tpu_oc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .wdata (push_row),
        .pop   (pop),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    // Gated so an empty FIFO presents zeros rather than stale storage.
    assign out_data  = out_valid ? fifo_head.data : '0;
    assign out_sat   = out_valid & fifo_head.sat;
    assign issue_err = issue_err_q;

endmodule
